// File: rtl/multi_project_wb_mux.sv
// multi_project_wb_mux: routes Caravel Wishbone to N_PROJ user projects by address window, muxes pads/IRQ of the active one
module multi_project_wb_mux #(
    parameter int          N_PROJ     = 4,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          SLOT_SHIFT = 16,
    parameter int          TIMEOUT    = 255,
    parameter int          IO_W       = 38
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [N_PROJ-1:0]        proj_cyc_o,
    output logic [N_PROJ-1:0]        proj_stb_o,
    output logic                     proj_we_o,
    output logic [3:0]               proj_sel_o,
    output logic [31:0]              proj_adr_o,
    output logic [31:0]              proj_dat_o,
    input  logic [N_PROJ-1:0]        proj_ack_i,
    input  logic [32*N_PROJ-1:0]     proj_dat_i,
    input  logic [IO_W*N_PROJ-1:0]   proj_io_out_i,
    input  logic [IO_W*N_PROJ-1:0]   proj_io_oeb_i,
    input  logic [3*N_PROJ-1:0]      proj_irq_i,
    output logic [IO_W-1:0]          io_out,
    output logic [IO_W-1:0]          io_oeb,
    output logic [2:0]               user_irq,
    output logic [N_PROJ-1:0]        active_o
);
    localparam int          IW       = (N_PROJ > 1) ? $clog2(N_PROJ) : 1;
    localparam logic [31:0] ADR_MASK = (32'd1 << SLOT_SHIFT) - 32'd1;
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [31:0] BLOCKED  = 32'hDEAD_BEEF;
    localparam logic [31:0] TO_DAT   = 32'hBADC_0FFE;

    typedef enum logic [1:0] {IDLE, FWD, ACK} state_t;

    state_t            state_q;
    logic              ack_q, we_q, stb_any;
    logic [31:0]       rdat_q, adr_q, wdat_q;
    logic [3:0]        sel_q;
    logic [N_PROJ-1:0] stb_q, active_q;
    logic [IW-1:0]     pslot_q;
    logic [7:0]        cnt_q;
    logic [7:0]        idx_q, idx_d, tcnt_q, tcnt_d;
    logic              en_q, en_d, err_q, err_d;

    logic [31:0] off, slot, pidx, ctrl_rd;
    logic        req, mapped, is_ctrl, is_proj, proj_ok, ack_hit, timeout, ctrl_wr;

    logic [31:0]     pdat_a [N_PROJ];
    logic [IO_W-1:0] pout_a [N_PROJ];
    logic [IO_W-1:0] poeb_a [N_PROJ];
    logic [2:0]      pirq_a [N_PROJ];

    for (genvar k = 0; k < N_PROJ; k++) begin : g_slot
        assign pdat_a[k] = proj_dat_i[32*k +: 32];
        assign pout_a[k] = proj_io_out_i[IO_W*k +: IO_W];
        assign poeb_a[k] = proj_io_oeb_i[IO_W*k +: IO_W];
        assign pirq_a[k] = proj_irq_i[3*k +: 3];
    end

    assign off     = wbs_adr_i - ADDR_BASE;
    assign slot    = off >> SLOT_SHIFT;
    assign pidx    = slot - 32'd1;
    assign req     = wbs_cyc_i & wbs_stb_i & (state_q == IDLE);
    assign mapped  = wbs_adr_i >= ADDR_BASE;
    assign is_ctrl = mapped && slot == 32'd0;
    assign is_proj = mapped && slot != 32'd0 && slot <= 32'(N_PROJ);
    assign proj_ok = is_proj && en_q && pidx == {24'd0, idx_q};
    assign ack_hit = proj_ack_i[pslot_q];
    assign timeout = state_q == FWD && !ack_hit && cnt_q == TO_LAST;
    assign ctrl_wr = req && is_ctrl && wbs_we_i;
    assign ctrl_rd = {8'd0, tcnt_q, 6'd0, err_q, en_q, idx_q};
    assign stb_any = |stb_q;

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdat_q;
    assign proj_cyc_o = stb_q;
    assign proj_stb_o = stb_q;
    assign proj_we_o  = we_q & stb_any;
    assign proj_sel_o = sel_q;
    assign proj_adr_o = adr_q;
    assign proj_dat_o = wdat_q;
    assign active_o   = active_q;
    assign io_out     = en_q ? pout_a[idx_q[IW-1:0]] : '0;
    assign io_oeb     = en_q ? poeb_a[idx_q[IW-1:0]] : '1;
    assign user_irq   = en_q ? pirq_a[idx_q[IW-1:0]] : 3'd0;

    // Control register next state; invalid idx write and blocked/unmapped/timed-out accesses raise err
    always_comb begin
        idx_d  = idx_q;
        en_d   = en_q;
        err_d  = err_q;
        tcnt_d = tcnt_q;
        if (ctrl_wr && wbs_sel_i[1]) begin
            en_d  = wbs_dat_i[8];
            err_d = wbs_dat_i[9] ? 1'b0 : err_q;
        end
        if (ctrl_wr && wbs_sel_i[2]) tcnt_d = '0;
        if (ctrl_wr && wbs_sel_i[0]) begin
            if ({24'd0, wbs_dat_i[7:0]} < 32'(N_PROJ)) idx_d = wbs_dat_i[7:0];
            else err_d = 1'b1;
        end
        if (req && !is_ctrl && !proj_ok) err_d = 1'b1;
        if (timeout) begin
            err_d  = 1'b1;
            tcnt_d = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
        end
    end

    // Control registers; active_o is built from next state so it moves together with idx/enable
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q    <= '0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
            tcnt_q   <= '0;
            active_q <= '0;
        end else begin
            idx_q    <= idx_d;
            en_q     <= en_d;
            err_q    <= err_d;
            tcnt_q   <= tcnt_d;
            active_q <= en_d ? N_PROJ'(1) << idx_d : '0;
        end
    end

    // Transaction FSM: accept in IDLE, forward to one project in FWD, single-cycle ack in ACK
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            pslot_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    we_q    <= wbs_we_i;
                    sel_q   <= wbs_sel_i;
                    adr_q   <= off & ADR_MASK;
                    wdat_q  <= wbs_dat_i;
                    pslot_q <= pidx[IW-1:0];
                    cnt_q   <= '0;
                    if (proj_ok) begin
                        stb_q   <= N_PROJ'(1) << pidx[IW-1:0];
                        state_q <= FWD;
                    end else begin
                        ack_q   <= 1'b1;
                        rdat_q  <= is_ctrl ? ctrl_rd : is_proj ? BLOCKED : '0;
                        state_q <= ACK;
                    end
                end
                FWD: if (ack_hit || timeout) begin
                    rdat_q  <= ack_hit ? pdat_a[pslot_q] : TO_DAT;
                    ack_q   <= 1'b1;
                    stb_q   <= '0;
                    state_q <= ACK;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_project_wb_mux.sv
// tb_multi_project_wb_mux: directed Wishbone vectors with a scoreboard-driven read-data monitor
module tb_multi_project_wb_mux;
    localparam int N = 4;
    localparam int IO_W = 38;

    logic clk = 1'b0;
    logic rst;
    logic stb, cyc, we;
    logic [3:0] sel;
    logic [31:0] adr, dat;
    logic wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [N-1:0] proj_cyc_o, proj_stb_o, proj_ack_i, active_o;
    logic proj_we_o;
    logic [3:0] proj_sel_o;
    logic [31:0] proj_adr_o, proj_dat_o;
    logic [32*N-1:0] proj_dat_i;
    logic [IO_W*N-1:0] proj_io_out_i, proj_io_oeb_i;
    logic [3*N-1:0] proj_irq_i;
    logic [IO_W-1:0] io_out, io_oeb;
    logic [2:0] user_irq;

    typedef struct packed {
        logic        ck;
        logic [31:0] exp;
        logic [7:0]  id;
    } sb_t;
    sb_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int resp_delay = -1;
    logic [31:0] resp_data, exp_padr, exp_pdat;
    logic [N-1:0] exp_stb;
    logic exp_pwe;
    logic last_saw;

    always #5 clk = ~clk;

    multi_project_wb_mux dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .proj_cyc_o(proj_cyc_o), .proj_stb_o(proj_stb_o), .proj_we_o(proj_we_o), .proj_sel_o(proj_sel_o),
        .proj_adr_o(proj_adr_o), .proj_dat_o(proj_dat_o), .proj_ack_i(proj_ack_i), .proj_dat_i(proj_dat_i),
        .proj_io_out_i(proj_io_out_i), .proj_io_oeb_i(proj_io_oeb_i), .proj_irq_i(proj_irq_i),
        .io_out(io_out), .io_oeb(io_oeb), .user_irq(user_irq), .active_o(active_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pad and IRQ sources: slot k drives distinct patterns so a wrong mux select is visible
    initial begin
        for (int k = 0; k < N; k++) begin
            proj_io_out_i[k*IO_W +: IO_W] = {6'(k + 1), 32'hC0DE_0000 | 32'(k)};
            proj_io_oeb_i[k*IO_W +: IO_W] = {6'd0, 32'h0000_F000 | 32'(k)};
            proj_irq_i[k*3 +: 3] = 3'(k + 1);
        end
    end

    // Project model: checks the forwarded request, then acks after resp_delay cycles
    initial begin
        proj_ack_i = '0;
        for (int k = 0; k < N; k++) proj_dat_i[k*32 +: 32] = 32'hEEEE_0000 | 32'(k);
        forever begin
            @(posedge clk);
            #2;
            if (|proj_stb_o && resp_delay >= 0) begin
                chk("p_stb", proj_stb_o, exp_stb);
                chk("p_cyc", proj_cyc_o, exp_stb);
                chk("p_adr", proj_adr_o, exp_padr);
                chk("p_we", proj_we_o, exp_pwe);
                if (exp_pwe) chk("p_dat", proj_dat_o, exp_pdat);
                for (int i = 0; i < resp_delay; i++) @(posedge clk);
                #1;
                proj_ack_i = exp_stb;
                for (int k = 0; k < N; k++)
                    proj_dat_i[k*32 +: 32] = exp_stb[k] ? resp_data : (32'hEEEE_0000 | 32'(k));
                @(posedge clk);
                #1;
                proj_ack_i = '0;
                chk("ack_follow", wbs_ack_o, 1'b1);
                chk("stb_drop", proj_stb_o, '0);
            end
        end
    end

    // Scoreboard monitor: every ack pops one expectation
    always @(negedge clk) begin
        if (wbs_ack_o) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_ack: got ack with data %0h, expected no ack", wbs_dat_o);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.ck) chk($sformatf("rdata_%0d", e.id), wbs_dat_o, e.exp);
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                        input logic ck, input logic [31:0] exp, input int exp_n, input logic [7:0] id);
        int n;
        logic done, saw;
        sb_t e;
        e.ck = ck;
        e.exp = exp;
        e.id = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        adr = a; we = w; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
        n = 0; done = 1'b0; saw = 1'b0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            saw |= |proj_stb_o;
            done = wbs_ack_o;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL no_ack_%0d: got no ack in %0d cycles, expected ack", id, n);
            e = sb.pop_back();
        end else begin
            chk($sformatf("latency_%0d", id), n, exp_n);
        end
        last_saw = saw;
    endtask

    task automatic chk_pads(input string nm, input logic [N-1:0] act_e, input logic [IO_W-1:0] o,
                            input logic [IO_W-1:0] oe, input logic [2:0] irq);
        chk({nm, "_active"}, active_o, act_e);
        chk({nm, "_io_out"}, io_out, o);
        chk({nm, "_io_oeb"}, io_oeb, oe);
        chk({nm, "_irq"}, user_irq, irq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
        exp_stb = '0; exp_padr = '0; exp_pdat = '0; exp_pwe = 1'b0; resp_data = '0; last_saw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_pads("reset", 4'b0000, '0, '1, 3'd0);
        chk("reset_ack", wbs_ack_o, 1'b0);
        chk("reset_stb", proj_stb_o, '0);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1, 1);
        xfer(32'h3000_0000, 1'b1, 4'b0011, 32'h0000_0102, 1'b0, 32'h0, 1, 2);
        chk_pads("sel2", 4'b0100, 38'h3_C0DE_0002, 38'h0_0000_F002, 3'd3);
        exp_stb = 4'b0100; exp_padr = 32'h10; resp_delay = 3; resp_data = 32'h1234_5678;
        xfer(32'h3003_0010, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1234_5678, 5, 3);
        resp_delay = -1;
        xfer(32'h3003_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'hBADC_0FFE, 256, 4);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0001_0302, 1, 5);
        exp_padr = 32'h4; resp_delay = 1; resp_data = 32'hCAFE_0001;
        xfer(32'h3003_0004, 1'b0, 4'hF, 32'h0, 1'b1, 32'hCAFE_0001, 3, 6);
        exp_padr = 32'h8; exp_pwe = 1'b1; exp_pdat = 32'h5555_AAAA; resp_delay = 0;
        xfer(32'h3003_0008, 1'b1, 4'hF, 32'h5555_AAAA, 1'b0, 32'h0, 2, 7);
        exp_pwe = 1'b0; resp_delay = -1;
        xfer(32'h3001_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1, 8);
        chk("inactive_no_stb", last_saw, 1'b0);
        xfer(32'h3000_0000, 1'b1, 4'b0010, 32'h0000_0300, 1'b0, 32'h0, 1, 9);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0001_0102, 1, 10);
        xfer(32'h3000_0000, 1'b1, 4'b0001, 32'h0000_0007, 1'b0, 32'h0, 1, 11);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0001_0302, 1, 12);
        xfer(32'h3000_0000, 1'b1, 4'b0100, 32'h0, 1'b0, 32'h0, 1, 13);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_0302, 1, 14);
        xfer(32'h3005_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1, 15);
        xfer(32'h2FFF_FFFC, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1, 16);
        xfer(32'h3000_0000, 1'b1, 4'b0010, 32'h0, 1'b0, 32'h0, 1, 17);
        chk_pads("disabled", 4'b0000, '0, '1, 3'd0);
        xfer(32'h3003_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1, 18);
        chk("disabled_no_stb", last_saw, 1'b0);
        xfer(32'h3000_0000, 1'b1, 4'b0011, 32'h0000_0301, 1'b0, 32'h0, 1, 19);
        chk_pads("sel1", 4'b0010, 38'h2_C0DE_0001, 38'h0_0000_F001, 3'd2);
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_0101, 1, 20);
        exp_stb = 4'b0010; exp_padr = 32'h20; resp_delay = 2; resp_data = 32'h0BAD_F00D;
        xfer(32'h3002_0020, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0BAD_F00D, 4, 21);
        resp_delay = -1;
        @(posedge clk);
        #1;
        adr = 32'h3002_0000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_stb", proj_stb_o, 4'b0010);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_stb", proj_stb_o, '0);
        chk("arst_cyc", proj_cyc_o, '0);
        chk("arst_ack", wbs_ack_o, 1'b0);
        chk_pads("arst", 4'b0000, '0, '1, 3'd0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1, 22);
        repeat (5) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
